// File: rtl/soc_system_ops_counter_if.sv
// Bundles the control inputs and snapshot outputs of the windowed op counter.
// The master drives start/abort/op_inc; the slave (counter) drives the results.
interface soc_system_ops_counter_if;
  logic        start;
  logic        abort;
  logic [2:0]  op_inc;
  logic [31:0] out_port;
  logic        sat;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, op_inc,
    input  out_port, sat, busy, done
  );

  modport slave (
    input  start, abort, op_inc,
    output out_port, sat, busy, done
  );
endinterface

// File: rtl/soc_system_ops_counter.sv
// Windowed operation counter: sums op_inc over WINDOW_CYCLES clocks and publishes
// a saturating 32-bit total that only changes at window end, so PIO reads stay coherent.
module soc_system_ops_counter #(
  parameter int unsigned WINDOW_CYCLES = 32'd50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  soc_system_ops_counter_if.slave bus
);

  localparam logic [31:0] REM_INIT = 32'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] rem_reg, rem_next;
  logic        acc_sat_reg, acc_sat_next;
  logic [31:0] out_port_reg, out_port_next;
  logic        sat_reg, sat_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic [32:0] sum_wide;
  logic        step_sat;
  logic [31:0] acc_step;

  // One accumulation step; the carry out marks this cycle as saturating.
  always_comb begin
    sum_wide = {1'b0, acc_reg} + {30'd0, bus.op_inc};
    step_sat = sum_wide[32];
    acc_step = step_sat ? 32'hFFFF_FFFF : sum_wide[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      acc_sat_reg  <= 1'b0;
      out_port_reg <= 32'd0;
      sat_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      rem_reg      <= rem_next;
      acc_sat_reg  <= acc_sat_next;
      out_port_reg <= out_port_next;
      sat_reg      <= sat_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    rem_next      = rem_reg;
    acc_sat_next  = acc_sat_reg;
    out_port_next = out_port_reg;
    sat_next      = sat_reg;
    done_next     = 1'b0;

    case (state_reg)
      RUN: begin
        // Abort outranks completion and drops this cycle's sample.
        if (bus.abort) begin
          state_next = IDLE;
        end else if (rem_reg == 32'd0) begin
          out_port_next = acc_step;
          sat_next      = acc_sat_reg | step_sat;
          done_next     = 1'b1;
          state_next    = HOLD;
        end else begin
          acc_next     = acc_step;
          acc_sat_next = acc_sat_reg | step_sat;
          rem_next     = rem_reg - 32'd1;
        end
      end
      default: begin
        if (bus.start) begin
          state_next   = RUN;
          acc_next     = 32'd0;
          acc_sat_next = 1'b0;
          rem_next     = REM_INIT;
        end
      end
    endcase

    busy_next = (state_next == RUN);
  end

  assign bus.out_port = out_port_reg;
  assign bus.sat      = sat_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: doc/soc_system_ops_counter.md
# soc_system_ops_counter

Windowed operation counter feeding the 32-bit read-only `ops` PIO input ports of the SoC. Sums per-cycle completion counts from a datapath over a fixed window of clock cycles. Publishes the total as a stable snapshot on `out_port`, which is wired directly to the PIO's `in_port`. `out_port` changes only at window end, so software reads of the PIO always return a coherent value.

## Interface
- `WINDOW_CYCLES`, default 50000000: window length in clock cycles, legal range 1..2^32-1.
- `clk`  in  1  system clock, same domain as the PIO.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a window.
- `abort`  in  1  cancels a running window.
- `op_inc`  in  3  number of operations completed this cycle, 0..7.
- `out_port`  out  32  last completed window total; connects to PIO `in_port`.
- `sat`  out  1  set when the snapshot in `out_port` saturated.
- `busy`  out  1  high while a window is running.
- `done`  out  1  one-cycle pulse when `out_port` and `sat` update.

## Operation
- Internal state:
  - 32-bit accumulator `acc`.
  - 32-bit down-counter `rem`.
  - sticky saturation bit `acc_sat`.
  - FSM with states IDLE, RUN, HOLD.
- Reset (async, active-high): FSM=IDLE; `acc`=0, `rem`=0, `acc_sat`=0; `out_port`=0, `sat`=0, `busy`=0, `done`=0.
- IDLE/HOLD with `start`=1: go to RUN. Set `acc`=0, `acc_sat`=0, `rem`=WINDOW_CYCLES-1.
- IDLE/HOLD with `abort` only: no effect. `start` wins over `abort` in these states.
- RUN, every cycle:
  - Compute `acc_next` = `acc` + `op_inc` as a 33-bit sum.
  - If bit 32 is set: `acc_next`=32'hFFFFFFFF and `acc_sat`←1.
  - Saturation is sticky for the rest of the window.
- RUN, `rem`≠0: `acc`←`acc_next`, `rem`←`rem`-1.
- RUN, `rem`=0 (last window cycle):
  - The cycle's `op_inc` is included.
  - `out_port`←`acc_next`, `sat`←`acc_sat` OR (this cycle saturated).
  - `done`←1 for one cycle; FSM→HOLD.
- RUN, `abort`=1:
  - FSM→IDLE. `out_port`, `sat` unchanged; no `done`.
  - `abort` wins over window completion in the same cycle.
  - That cycle's `op_inc` is discarded.
- RUN, `start`=1: ignored; the window is not restarted.
- HOLD and IDLE behave identically. HOLD only records that at least one window has completed; `busy`=0 in both.
- `busy`=1 iff FSM=RUN.
- `op_inc` is sampled only in RUN and ignored in IDLE/HOLD.

## Timing
- `start` sampled at rising edge E0. RUN covers the cycles ending at edges E1..EW, where W=WINDOW_CYCLES.
- Exactly W samples of `op_inc` are summed, taken at edges E1..EW.
- `out_port`, `sat` and `done` update at edge EW and are visible in the cycle after it.
- The PIO registers `out_port` one edge later, so software sees the new value from EW+1 onward.
- `busy` rises after E0 and falls after EW.
- `done` is high for exactly one cycle.
- Back-to-back windows: `start` asserted in the first HOLD cycle (same cycle as `done`) gives one idle cycle between windows. No op counts from that gap cycle are accumulated.
- W=1: a single sample; `done` follows `start` by one cycle.
- Reset asserted mid-window: all outputs clear asynchronously, including `out_port`=0. No `done` is produced.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset check, W=8: assert `reset` asynchronously mid-cycle → `out_port`=0, `sat`=0, `busy`=0, `done`=0 immediately. Pulse `start` during reset → still IDLE after release.
- Basic window, W=8: pulse `start`, drive `op_inc`=3 for 8 cycles → `done` one cycle, `out_port`=24, `sat`=0. `busy` high exactly 8 cycles.
- Window boundary, W=8: `op_inc`=7 on the cycle before `start`, 1 during the window, 7 on the first HOLD cycle → `out_port`=8.
- Abort, W=8: after `start` with `op_inc`=2, assert `abort` on the 8th RUN cycle → IDLE, no `done`, `out_port` holds the previous value. Next `start` with `abort` held high → RUN begins.
- Saturation, W=4: force `acc`=32'hFFFFFFFA via `op_inc`=7 for 4 cycles → `out_port`=32'hFFFFFFFF, `sat`=1. Next window with `op_inc`=1 → `out_port`=4, `sat`=0.
- Restart and W=1: in RUN, pulse `start` → ignored, total unaffected. On the `done` cycle, pulse `start` → exactly one gap cycle, second window correct. With W=1, `start` and `op_inc`=5 → `out_port`=5 one cycle later.
